// File: rtl/apb_pkg.sv
// Shared APB definitions for the requester and the memory slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic SEL_S1 = 1'b0;
  localparam logic SEL_S2 = 1'b1;

  localparam int MEM_DEPTH_DEF = 64;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; tc_o flags that the next un-ready cycle hits the limit.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (inc_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, SETUP/ACCESS on one of two slaves,
// single-cycle response strobe out. Owns slave decode, PRDATA mux and timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int TIMEOUT   = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  apb_state_e        state_q, state_d;
  logic              write_q, write_d, sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              psel1_q, psel2_q, penable_q, rsp_valid_q;
  logic              cnt_inc, cnt_clr, cnt_tc;
  logic              ready;
  logic [DATA_W-1:0] prdata;
  logic              xfer_d;

  // Only the latched slave's handshake and data are looked at.
  assign ready  = (sel_q == SEL_S2) ? PREADY2 : PREADY1;
  assign prdata = (sel_q == SEL_S2) ? PRDATA2 : PRDATA1;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        sel_d   = req_sel;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = 1'b0;
        if (32'(req_addr) >= 32'(MEM_DEPTH)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (ready) begin
          rdata_d = write_q ? '0 : prdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer_d = (state_d == SETUP) || (state_d == ACCESS);

  // APB/response outputs are registered from the next state so they line up with it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      sel_q       <= SEL_S1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      psel1_q     <= xfer_d && (sel_d == SEL_S1);
      psel2_q     <= xfer_d && (sel_d == SEL_S2);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= (state_d == RESP);
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;

endmodule
